network_class_decoder: RTL and testbench
========================================

Name: network_class_decoder

Overview:
- Consumes the output-layer result of the neural network: the aligned vector of NUM_CLASSES signed fixed-point values plus the single valid pulse and overflow flag.
- Serially scans the vector, one element per cycle, and produces:
  - the winning class index (argmax),
  - the winner-versus-runner-up confidence margin,
  - the bipolar sign code.
- Presents the result on a valid/ready handshake to the downstream consumer (result register bank or host interface).
- The network has no backpressure, so inputs arriving while busy are dropped and counted.

Parameters:
- WIDTH, 8, fixed-point word width (matches network FP_WIDTH).
- FRAC_BITS, 5, fractional bits. Informational only; no scaling is applied.
- NUM_CLASSES, 3, number of network outputs (matches OL_NEURONS), must be >= 1.
- IDX_WIDTH, 2, class index width, must be >= max(1, clog2(NUM_CLASSES)).
- CNT_WIDTH, 8, drop counter width.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RSTN  in  1  reset, asynchronous assert, active-low.
- VALUES_IN  in  NUM_CLASSES*WIDTH  signed outputs; class i occupies bits [i*WIDTH +: WIDTH].
- VALID_IN  in  1  single-cycle pulse qualifying VALUES_IN.
- OVERFLOW_IN  in  1  network overflow flag, sampled together with VALID_IN.
- CLASS_OUT  out  IDX_WIDTH  argmax index.
- MARGIN_OUT  out  WIDTH+1  max minus second max, unsigned, never negative.
- BIPOLAR_OUT  out  NUM_CLASSES  bit i = 1 when class i value >= 0 (sign bit clear).
- OVF_OUT  out  1  OVERFLOW_IN captured with this result.
- VALID_OUT  out  1  result valid.
- READY_IN  in  1  downstream accepts the result.
- BUSY  out  1  high in SCAN or DONE.
- DROP  out  1  one-cycle pulse when a VALID_IN is discarded.
- DROP_COUNT  out  CNT_WIDTH  saturating count of drops.

Behaviour:
- Reset (RSTN low, asynchronous): FSM goes to IDLE. All outputs are 0; DROP_COUNT is 0. A reset mid-scan or mid-DONE discards the in-flight result with no output.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - On VALID_IN, capture VALUES_IN and OVERFLOW_IN into a holding register.
  - Clear index counter k to 0, max to the most-negative value, second to the most-negative value, best to 0.
  - Go to SCAN.
- SCAN, one element per cycle, element v = holding[k]:
  - If v > max (strict signed compare): second <= max, max <= v, best <= k.
  - Else if v > second: second <= v.
  - bipolar[k] <= ~v[WIDTH-1].
  - k increments. After k = NUM_CLASSES-1 is processed, go to DONE.
  - Ties resolve to the lowest index, because replacement requires strict greater-than.
- Entering DONE:
  - CLASS_OUT <= best.
  - MARGIN_OUT <= max - second, computed in WIDTH+1-bit signed arithmetic with sign-extended operands, so no wrap is possible.
  - BIPOLAR_OUT and OVF_OUT are registered. VALID_OUT = 1.
- NUM_CLASSES = 1: second stays most-negative, so MARGIN_OUT = v + 2^(WIDTH-1).
- Latency: a VALID_IN in cycle t gives VALID_OUT high from cycle t+NUM_CLASSES+1. For the defaults, VALID_IN in cycle 0 gives VALID_OUT in cycle 4.
- DONE:
  - All result outputs are held stable while VALID_OUT is high and READY_IN is low.
  - VALID_OUT & READY_IN is the transfer. The next cycle VALID_OUT = 0 and the FSM returns to IDLE.
  - The result output values persist after transfer until the next DONE.
- Drop rule: VALID_IN while in SCAN or DONE is ignored.
  - DROP pulses for 1 cycle.
  - DROP_COUNT increments and saturates at all-ones.
  - The holding register is not disturbed.
- VALID_IN in the same cycle as a DONE transfer is also dropped. Acceptance happens only in IDLE.
- BUSY = (state != IDLE), combinational from the state register.

Test Plan (WIDTH=8, FRAC_BITS=5, NUM_CLASSES=3; 1.0 = 0x20, -1.0 = 0xE0; list is class0, class1, class2):
- Basic decode: VALUES {0x20, 0xE0, 0xE0}, VALID_IN at cycle 0, READY_IN = 1 -> VALID_OUT in cycle 4 only; CLASS_OUT = 0, MARGIN_OUT = 0x040, BIPOLAR_OUT = 3'b001, OVF_OUT = 0.
- Tie and ordering: {0x10, 0x10, 0xE0} -> CLASS_OUT = 0, MARGIN_OUT = 0. Then {0xE0, 0x00, 0x20} -> CLASS_OUT = 2, MARGIN_OUT = 0x020, BIPOLAR_OUT = 3'b110.
- Extremes: {0x80, 0x80, 0x7F} -> CLASS_OUT = 2, MARGIN_OUT = 0x0FF (no wrap).
- Backpressure and drop:
  - READY_IN = 0 for 10 cycles after VALID_OUT rises -> all result outputs are stable throughout.
  - A second VALID_IN issued during DONE -> DROP pulse and DROP_COUNT = 1; the result is unchanged.
  - Raising READY_IN -> transfer, and the FSM is in IDLE one cycle later.
- Overflow and saturation:
  - OVERFLOW_IN = 1 with VALID_IN -> OVF_OUT = 1 on that result only.
  - 300 drops -> DROP_COUNT = 0xFF.
- Reset mid-scan: RSTN low in cycle 2 of SCAN -> all outputs 0 immediately. The next VALID_IN after reset release decodes normally.

Source files
------------

// File: rtl/network_class_decoder.sv
// rtl/network_class_decoder.sv - serial argmax/margin/sign decoder for the network output layer
`timescale 1ns/1ps
module network_class_decoder #(
    parameter int WIDTH       = 8,
    parameter int FRAC_BITS   = 5,
    parameter int NUM_CLASSES = 3,
    parameter int IDX_WIDTH   = 2,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                         CLK,
    input  logic                         RSTN,
    input  logic [NUM_CLASSES*WIDTH-1:0] VALUES_IN,
    input  logic                         VALID_IN,
    input  logic                         OVERFLOW_IN,
    output logic [IDX_WIDTH-1:0]         CLASS_OUT,
    output logic [WIDTH:0]               MARGIN_OUT,
    output logic [NUM_CLASSES-1:0]       BIPOLAR_OUT,
    output logic                         OVF_OUT,
    output logic                         VALID_OUT,
    input  logic                         READY_IN,
    output logic                         BUSY,
    output logic                         DROP,
    output logic [CNT_WIDTH-1:0]         DROP_COUNT
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [WIDTH-1:0]     MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [IDX_WIDTH-1:0] LAST_K   = IDX_WIDTH'(NUM_CLASSES - 1);

    if (NUM_CLASSES < 1 || IDX_WIDTH < $clog2(NUM_CLASSES) || FRAC_BITS > WIDTH) begin : g_bad_params
        $error("network_class_decoder: illegal parameter combination");
    end

    logic [1:0]                   state_q, state_d;
    logic [NUM_CLASSES*WIDTH-1:0] hold_q, hold_d;
    logic                         hold_ovf_q, hold_ovf_d;
    logic [IDX_WIDTH-1:0]         k_q, k_d;
    logic [WIDTH-1:0]             max_q, max_d;
    logic [WIDTH-1:0]             second_q, second_d;
    logic [IDX_WIDTH-1:0]         best_q, best_d;
    logic [NUM_CLASSES-1:0]       bip_q, bip_d;
    logic [IDX_WIDTH-1:0]         class_q, class_d;
    logic [WIDTH:0]               margin_q, margin_d;
    logic [NUM_CLASSES-1:0]       bipolar_q, bipolar_d;
    logic                         ovf_q, ovf_d;
    logic                         valid_q, valid_d;
    logic                         drop_q, drop_d;
    logic [CNT_WIDTH-1:0]         drop_cnt_q, drop_cnt_d;

    logic [WIDTH-1:0]             elem;
    logic [WIDTH-1:0]             scan_max;
    logic [WIDTH-1:0]             scan_sec;
    logic [IDX_WIDTH-1:0]         scan_best;
    logic [NUM_CLASSES-1:0]       scan_bip;

    // Running max/second/best including the element under the cursor.
    always_comb begin
        elem = '0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (k_q == IDX_WIDTH'(i)) begin
                elem = hold_q[i*WIDTH +: WIDTH];
            end
        end
        scan_max  = max_q;
        scan_sec  = second_q;
        scan_best = best_q;
        if ($signed(elem) > $signed(max_q)) begin
            scan_sec  = max_q;
            scan_max  = elem;
            scan_best = k_q;
        end else if ($signed(elem) > $signed(second_q)) begin
            scan_sec = elem;
        end
        scan_bip = bip_q;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (k_q == IDX_WIDTH'(i)) begin
                scan_bip[i] = ~elem[WIDTH-1];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        hold_ovf_d = hold_ovf_q;
        k_d        = k_q;
        max_d      = max_q;
        second_d   = second_q;
        best_d     = best_q;
        bip_d      = bip_q;
        class_d    = class_q;
        margin_d   = margin_q;
        bipolar_d  = bipolar_q;
        ovf_d      = ovf_q;
        valid_d    = valid_q;
        drop_d     = 1'b0;
        drop_cnt_d = drop_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (VALID_IN) begin
                    hold_d     = VALUES_IN;
                    hold_ovf_d = OVERFLOW_IN;
                    k_d        = '0;
                    max_d      = MOST_NEG;
                    second_d   = MOST_NEG;
                    best_d     = '0;
                    bip_d      = '0;
                    state_d    = ST_SCAN;
                end
            end
            ST_SCAN: begin
                max_d    = scan_max;
                second_d = scan_sec;
                best_d   = scan_best;
                bip_d    = scan_bip;
                k_d      = k_q + IDX_WIDTH'(1);
                if (k_q == LAST_K) begin
                    state_d   = ST_DONE;
                    class_d   = scan_best;
                    // Sign-extend before subtracting so the difference cannot wrap.
                    margin_d  = {scan_max[WIDTH-1], scan_max} - {scan_sec[WIDTH-1], scan_sec};
                    bipolar_d = scan_bip;
                    ovf_d     = hold_ovf_q;
                    valid_d   = 1'b1;
                end
            end
            ST_DONE: begin
                if (READY_IN) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase

        if (VALID_IN && state_q != ST_IDLE) begin
            drop_d = 1'b1;
            if (!(&drop_cnt_q)) begin
                drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            hold_ovf_q <= 1'b0;
            k_q        <= '0;
            max_q      <= '0;
            second_q   <= '0;
            best_q     <= '0;
            bip_q      <= '0;
            class_q    <= '0;
            margin_q   <= '0;
            bipolar_q  <= '0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
            drop_q     <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            hold_ovf_q <= hold_ovf_d;
            k_q        <= k_d;
            max_q      <= max_d;
            second_q   <= second_d;
            best_q     <= best_d;
            bip_q      <= bip_d;
            class_q    <= class_d;
            margin_q   <= margin_d;
            bipolar_q  <= bipolar_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
            drop_q     <= drop_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign CLASS_OUT   = class_q;
    assign MARGIN_OUT  = margin_q;
    assign BIPOLAR_OUT = bipolar_q;
    assign OVF_OUT     = ovf_q;
    assign VALID_OUT   = valid_q;
    assign BUSY        = (state_q != ST_IDLE);
    assign DROP        = drop_q;
    assign DROP_COUNT  = drop_cnt_q;

endmodule

// File: tb/tb_network_class_decoder.sv
// tb/tb_network_class_decoder.sv - directed scoreboard bench for network_class_decoder
`timescale 1ns/1ps
module tb_network_class_decoder;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic [23:0] VALUES_IN = '0;
    logic        VALID_IN = 1'b0;
    logic        OVERFLOW_IN = 1'b0;
    logic [1:0]  CLASS_OUT;
    logic [8:0]  MARGIN_OUT;
    logic [2:0]  BIPOLAR_OUT;
    logic        OVF_OUT;
    logic        VALID_OUT;
    logic        READY_IN = 1'b0;
    logic        BUSY;
    logic        DROP;
    logic [7:0]  DROP_COUNT;

    always #5 CLK = ~CLK;

    network_class_decoder #(
        .WIDTH(8), .FRAC_BITS(5), .NUM_CLASSES(3), .IDX_WIDTH(2), .CNT_WIDTH(8)
    ) dut (
        .CLK(CLK), .RSTN(RSTN), .VALUES_IN(VALUES_IN), .VALID_IN(VALID_IN),
        .OVERFLOW_IN(OVERFLOW_IN), .CLASS_OUT(CLASS_OUT), .MARGIN_OUT(MARGIN_OUT),
        .BIPOLAR_OUT(BIPOLAR_OUT), .OVF_OUT(OVF_OUT), .VALID_OUT(VALID_OUT),
        .READY_IN(READY_IN), .BUSY(BUSY), .DROP(DROP), .DROP_COUNT(DROP_COUNT)
    );

    typedef struct packed {
        logic [1:0] cls;
        logic [8:0] margin;
        logic [2:0] bip;
        logic       ovf;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [23:0] pack(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2);
        return {c2, c1, c0};
    endfunction

    // Reference: first-index maximum, then best of the remaining classes.
    function automatic exp_t model(input logic [23:0] v, input logic ovf);
        exp_t r;
        int   val[3];
        int   best;
        int   sec;
        logic signed [7:0] b;
        for (int i = 0; i < 3; i++) begin
            b = v[i*8 +: 8];
            val[i] = b;
        end
        best = 0;
        for (int i = 1; i < 3; i++) if (val[i] > val[best]) best = i;
        sec = -128;
        for (int i = 0; i < 3; i++) if (i != best && val[i] > sec) sec = val[i];
        r.cls    = 2'(best);
        r.margin = 9'(val[best] - sec);
        for (int i = 0; i < 3; i++) r.bip[i] = (val[i] >= 0);
        r.ovf    = ovf;
        return r;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_exp(input logic [23:0] v, input logic ovf, input exp_t e);
        VALUES_IN   = v;
        OVERFLOW_IN = ovf;
        VALID_IN    = 1'b1;
        sb.push_back(e);
        tick();
        VALID_IN    = 1'b0;
        OVERFLOW_IN = 1'b0;
    endtask

    task automatic get_result(input string tag, input int exp_lat, output exp_t e);
        int cyc = 0;
        e = '0;
        while (!VALID_OUT && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, " valid"}, VALID_OUT, 1);
        if (exp_lat >= 0) check({tag, " latency"}, cyc, exp_lat);
        if (VALID_OUT && sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, " class"}, CLASS_OUT, e.cls);
            check({tag, " margin"}, MARGIN_OUT, e.margin);
            check({tag, " bipolar"}, BIPOLAR_OUT, e.bip);
            check({tag, " ovf"}, OVF_OUT, e.ovf);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " class"}, CLASS_OUT, 0);
        check({tag, " margin"}, MARGIN_OUT, 0);
        check({tag, " bipolar"}, BIPOLAR_OUT, 0);
        check({tag, " ovf"}, OVF_OUT, 0);
        check({tag, " valid"}, VALID_OUT, 0);
        check({tag, " busy"}, BUSY, 0);
        check({tag, " drop"}, DROP, 0);
        check({tag, " drop_count"}, DROP_COUNT, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic [23:0] rv;

        tick();
        tick();
        check_zero("reset");
        RSTN = 1'b1;
        tick();

        // Basic decode with READY_IN already high.
        READY_IN = 1'b1;
        send_exp(pack(8'h20, 8'hE0, 8'hE0), 1'b0, '{cls:2'd0, margin:9'h040, bip:3'b001, ovf:1'b0});
        check("basic busy in scan", BUSY, 1);
        check("basic no early valid", VALID_OUT, 0);
        get_result("basic", 3, e);
        tick();
        check("basic valid drops", VALID_OUT, 0);
        check("basic back to idle", BUSY, 0);

        send_exp(pack(8'h10, 8'h10, 8'hE0), 1'b0, '{cls:2'd0, margin:9'h000, bip:3'b011, ovf:1'b0});
        get_result("tie", 3, e);
        tick();
        send_exp(pack(8'hE0, 8'h00, 8'h20), 1'b0, '{cls:2'd2, margin:9'h020, bip:3'b110, ovf:1'b0});
        get_result("order", 3, e);
        tick();
        send_exp(pack(8'h80, 8'h80, 8'h7F), 1'b0, '{cls:2'd2, margin:9'h0FF, bip:3'b100, ovf:1'b0});
        get_result("extremes", 3, e);
        tick();

        // Backpressure with a drop while holding DONE.
        READY_IN = 1'b0;
        send_exp(pack(8'h05, 8'h30, 8'hF0), 1'b0, '{cls:2'd1, margin:9'h02B, bip:3'b011, ovf:1'b0});
        get_result("bp", 3, e);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                VALUES_IN = pack(8'h7F, 8'h00, 8'h00);
                VALID_IN  = 1'b1;
            end
            tick();
            VALID_IN = 1'b0;
            check("bp stable", {VALID_OUT, CLASS_OUT, MARGIN_OUT, BIPOLAR_OUT, OVF_OUT},
                  {1'b1, e.cls, e.margin, e.bip, e.ovf});
            if (i == 3) begin
                check("bp drop pulse", DROP, 1);
                check("bp drop count", DROP_COUNT, 1);
            end
            if (i == 4) check("bp drop one cycle", DROP, 0);
        end
        READY_IN = 1'b1;
        VALID_IN = 1'b1;
        tick();
        VALID_IN = 1'b0;
        check("xfer valid low", VALID_OUT, 0);
        check("xfer idle", BUSY, 0);
        check("xfer drop", DROP, 1);
        check("xfer drop count", DROP_COUNT, 2);
        repeat (5) tick();
        check("xfer no extra result", VALID_OUT, 0);
        check("xfer result persists", {CLASS_OUT, MARGIN_OUT}, {e.cls, e.margin});

        send_exp(pack(8'hE0, 8'hE0, 8'h20), 1'b1, '{cls:2'd2, margin:9'h040, bip:3'b100, ovf:1'b1});
        get_result("ovf set", 3, e);
        tick();
        send_exp(pack(8'h20, 8'hE0, 8'hE0), 1'b0, '{cls:2'd0, margin:9'h040, bip:3'b001, ovf:1'b0});
        get_result("ovf clear", 3, e);
        tick();

        for (int i = 0; i < 4; i++) begin
            rv = 24'($urandom);
            send_exp(rv, 1'(i), model(rv, 1'(i)));
            get_result("random", 3, e);
            tick();
        end

        // Drop counter saturation while a result is held.
        READY_IN = 1'b0;
        send_exp(pack(8'h7F, 8'h80, 8'h00), 1'b0, '{cls:2'd0, margin:9'h07F, bip:3'b101, ovf:1'b0});
        get_result("sat", 3, e);
        VALUES_IN = pack(8'h00, 8'h7F, 8'h00);
        VALID_IN  = 1'b1;
        repeat (300) tick();
        VALID_IN = 1'b0;
        tick();
        check("sat drop count", DROP_COUNT, 8'hFF);
        check("sat result held", {VALID_OUT, CLASS_OUT, MARGIN_OUT, BIPOLAR_OUT},
              {1'b1, e.cls, e.margin, e.bip});
        READY_IN = 1'b1;
        tick();
        check("sat idle", BUSY, 0);

        // Reset in the second SCAN cycle.
        send_exp(pack(8'h40, 8'h10, 8'h00), 1'b1, '{cls:2'd0, margin:9'h030, bip:3'b111, ovf:1'b1});
        tick();
        RSTN = 1'b0;
        #1;
        check_zero("midscan reset");
        void'(sb.pop_back());
        repeat (3) tick();
        check("reset no result", VALID_OUT, 0);
        RSTN = 1'b1;
        tick();
        send_exp(pack(8'h10, 8'h50, 8'h40), 1'b0, '{cls:2'd1, margin:9'h010, bip:3'b111, ovf:1'b0});
        get_result("post reset", 3, e);
        tick();
        check("post reset idle", BUSY, 0);
        check("scoreboard empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
